// File: rtl/cache_tag_lookup.sv
// Set-associative tag lookup in front of the L1 LRU block: searches one way per cycle,
// classifies hit / fill-empty / replace, runs the LRU handshake and installs new tags.
module cache_tag_lookup #(
  parameter  int WAY             = 4,
  parameter  int BLOCK_SIZE_BYTE = 16,
  parameter  int CACHE_SIZE_BYTE = 32768,
  parameter  int ADDR_WIDTH      = 32,
  localparam int SET             = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
  localparam int SET_INDEX       = $clog2(SET),
  localparam int OFFSET          = $clog2(BLOCK_SIZE_BYTE),
  localparam int TAG_W           = ADDR_WIDTH - SET_INDEX - OFFSET
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_evict,
  output logic [4:0]            resp_way,
  output logic [SET_INDEX-1:0]  lru_index,
  output logic                  lru_start,
  output logic                  lru_found,
  output logic                  lru_updated,
  output logic                  lru_replace,
  output logic [4:0]            lru_way_index,
  input  logic                  lru_block_replace,
  input  logic [4:0]            lru_replace_index
);
  localparam int WIW = $clog2(WAY);
  localparam logic [WIW-1:0] LAST_W = WIW'(WAY - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, SEARCH = 3'd1, LRU_REQ = 3'd2, LRU_WAIT = 3'd3, RESP = 3'd4
  } state_t;
  typedef enum logic [1:0] {K_HIT = 2'd0, K_FILL = 2'd1, K_REPL = 2'd2} kind_t;

  state_t               state, state_nxt;
  kind_t                kind, kind_nxt;
  logic [WIW-1:0]       w, w_nxt;
  logic [4:0]           hit_way, hit_nxt, empty_way, empty_nxt;
  logic [4:0]           wait_cnt, cnt_nxt, way_out_nxt, rsp_way_nxt, w_plus1;
  logic [SET_INDEX-1:0] cur_set, set_nxt;
  logic [TAG_W-1:0]     cur_tag, tag_nxt;
  logic [TAG_W-1:0]     tag_mem [SET][WAY];
  logic [WAY-1:0]       valid_mem [SET];
  logic                 wr_en, cur_valid, cur_match;
  logic [WIW-1:0]       wr_way, victim;
  logic                 addr_offset_unused;

  assign addr_offset_unused = ^req_addr[OFFSET-1:0];
  assign cur_valid = valid_mem[cur_set][w];
  assign cur_match = (tag_mem[cur_set][w] == cur_tag);
  assign w_plus1   = 5'(w) + 5'd1;

  // Out-of-range victim indices from the LRU fall back to way 0.
  always_comb begin
    if (lru_replace_index >= 5'(WAY)) begin
      victim = '0;
    end else begin
      victim = lru_replace_index[WIW-1:0];
    end
  end

  // Next-state, search bookkeeping and tag-install decode.
  always_comb begin
    state_nxt   = state;
    kind_nxt    = kind;
    w_nxt       = w;
    hit_nxt     = hit_way;
    empty_nxt   = empty_way;
    cnt_nxt     = wait_cnt;
    set_nxt     = cur_set;
    tag_nxt     = cur_tag;
    way_out_nxt = lru_way_index;
    rsp_way_nxt = 5'd0;
    wr_en       = 1'b0;
    wr_way      = '0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt   = SEARCH;
          w_nxt       = '0;
          hit_nxt     = 5'd0;
          empty_nxt   = 5'd0;
          set_nxt     = req_addr[OFFSET+SET_INDEX-1:OFFSET];
          tag_nxt     = req_addr[ADDR_WIDTH-1:ADDR_WIDTH-TAG_W];
          way_out_nxt = 5'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEARCH: begin
        if (cur_valid && cur_match && (hit_way == 5'd0)) begin
          hit_nxt = w_plus1;
        end else begin
          hit_nxt = hit_way;
        end
        if (!cur_valid && (empty_way == 5'd0)) begin
          empty_nxt = w_plus1;
        end else begin
          empty_nxt = empty_way;
        end
        if (w == LAST_W) begin
          state_nxt = LRU_REQ;
          if (hit_nxt != 5'd0) begin
            kind_nxt    = K_HIT;
            way_out_nxt = hit_nxt;
          end else if (empty_nxt != 5'd0) begin
            kind_nxt    = K_FILL;
            way_out_nxt = empty_nxt;
          end else begin
            kind_nxt    = K_REPL;
            way_out_nxt = 5'd0;
          end
        end else begin
          w_nxt = w + WIW'(1);
        end
      end
      LRU_REQ: begin
        state_nxt = LRU_WAIT;
        cnt_nxt   = 5'd0;
        if (kind == K_FILL) begin
          wr_en  = 1'b1;
          wr_way = WIW'(empty_way - 5'd1);
        end else begin
          wr_en = 1'b0;
        end
      end
      LRU_WAIT: begin
        if (kind == K_REPL) begin
          if (lru_block_replace) begin
            wr_en       = 1'b1;
            wr_way      = victim;
            rsp_way_nxt = 5'(victim) + 5'd1;
            state_nxt   = RESP;
          end else begin
            state_nxt = LRU_WAIT;
          end
        end else if (wait_cnt == 5'(WAY)) begin
          state_nxt   = RESP;
          rsp_way_nxt = (kind == K_HIT) ? hit_way : empty_way;
        end else begin
          cnt_nxt = wait_cnt + 5'd1;
        end
      end
      RESP: begin
        state_nxt   = IDLE;
        way_out_nxt = 5'd0;
      end
      default: begin
        state_nxt   = IDLE;
        way_out_nxt = 5'd0;
      end
    endcase
  end

  // Control registers and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      kind          <= K_HIT;
      w             <= '0;
      hit_way       <= 5'd0;
      empty_way     <= 5'd0;
      wait_cnt      <= 5'd0;
      cur_set       <= '0;
      cur_tag       <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_evict    <= 1'b0;
      resp_way      <= 5'd0;
      lru_index     <= '0;
      lru_start     <= 1'b0;
      lru_found     <= 1'b0;
      lru_updated   <= 1'b0;
      lru_replace   <= 1'b0;
      lru_way_index <= 5'd0;
    end else begin
      state         <= state_nxt;
      kind          <= kind_nxt;
      w             <= w_nxt;
      hit_way       <= hit_nxt;
      empty_way     <= empty_nxt;
      wait_cnt      <= cnt_nxt;
      cur_set       <= set_nxt;
      cur_tag       <= tag_nxt;
      req_ready     <= (state_nxt == IDLE);
      resp_valid    <= (state_nxt == RESP);
      resp_hit      <= (state_nxt == RESP) && (kind_nxt == K_HIT);
      resp_evict    <= (state_nxt == RESP) && (kind_nxt == K_REPL);
      resp_way      <= rsp_way_nxt;
      lru_index     <= set_nxt;
      lru_start     <= (state_nxt == LRU_REQ);
      lru_found     <= (state_nxt == LRU_REQ) && (kind_nxt == K_HIT);
      lru_updated   <= (state_nxt == LRU_REQ) && (kind_nxt == K_FILL);
      lru_replace   <= (state_nxt == LRU_REQ) && (kind_nxt == K_REPL);
      lru_way_index <= way_out_nxt;
    end
  end

  // Valid bits: cleared by reset, set when a tag is installed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET; s++) begin
        valid_mem[s] <= '0;
      end
    end else if (wr_en) begin
      valid_mem[cur_set][wr_way] <= 1'b1;
    end
  end

  // Tag storage carries no reset; writes only happen outside reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[cur_set][wr_way] <= cur_tag;
    end
  end
endmodule
